map_hub_sw: RTL and testbench
=============================

# map_hub_sw

Parametrised mapper hub with glitch-free switching. It selects one of `CH` mapper output buses (or the nominal fallback) by comparing `map_idx` against a per-slot ID table, and registers the result onto `map_out`. A selection change commits only after `map_idx` has held one value long enough (debounce) and after the outputs have been forced to zero for a quiet window. It sits between the mapper instances and the cartridge bus drivers, replacing a purely combinational index mux.

## Interface
- `CH`, 16, number of mapper slots (≥1)
- `IDX_W`, 8, mapper index width
- `DW`, 64, mapper output bus width
- `STABLE`, 4, cycles `map_idx` must hold after first change (≥1)
- `QUIET`, 8, zero-output cycles before commit (≥1)

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `map_idx`  in  IDX_W  requested mapper number
- `slot_id`  in  CH*IDX_W  slot k ID at bits [k*IDX_W +: IDX_W]
- `map_in`  in  CH*DW  slot k output at bits [k*DW +: DW]
- `map_nom`  in  DW  nominal (fallback) mapper output
- `map_out`  out  DW  registered selected output
- `cur_idx`  out  IDX_W  committed mapper index
- `hit`  out  1  committed index matched a slot
- `busy`  out  1  high in DEBOUNCE or QUIET
- `sw_cnt`  out  16  committed-switch counter (see Configuration)

## Operation
- State machine: ACTIVE, DEBOUNCE, QUIET. Internal: `pend_idx`, `cnt`, `cur_valid`.
- Lookup is combinational on `cur_idx`: the lowest k with `slot_id[k]==cur_idx` wins and `hit`=1. If no slot matches, `map_nom` is used and `hit`=0.
- ACTIVE:
  - `map_out` <= looked-up bus.
  - If `map_idx != cur_idx`: enter DEBOUNCE, `pend_idx`<=`map_idx`, `cnt`<=0.
- DEBOUNCE:
  - `map_out` <= looked-up bus if `cur_valid`, else 0.
  - If `map_idx != pend_idx`: `pend_idx`<=`map_idx`, `cnt`<=0.
  - Else if `cnt == STABLE-1`, decide:
    - If `cur_valid` and `pend_idx==cur_idx`: go to ACTIVE with no blanking.
    - Otherwise: go to QUIET, `cnt`<=0, `map_out`<=0.
  - Else `cnt`++.
- QUIET:
  - `map_out`<=0; a `map_idx` change is ignored.
  - When `cnt == QUIET-1`: `cur_idx`<=`pend_idx`, `cur_valid`<=1, go to ACTIVE.
  - Else `cnt`++.
  - A `map_idx` change during QUIET is handled in ACTIVE after commit.
- `cnt` width = clog2(max(STABLE,QUIET)+1).

## Timing
- Reset values:
  - Outputs: `map_out`=0, `cur_idx`=0, `hit` reflects the lookup of 0, `busy`=1, `sw_cnt`=0.
  - Internal: state DEBOUNCE, `pend_idx`<=`map_idx`, `cnt`=0, `cur_valid`=0.
- Reset mid-operation aborts any switch. The first commit after reset always passes through QUIET.
- Switch latency: let `map_idx` change before edge E0 and stay stable. Then:
  - `map_out`=0 from edge E0+STABLE.
  - The new mapping appears on `map_out` at edge E0+STABLE+QUIET+1.
  - The blank lasts QUIET+1 cycles.
- Selection latency in ACTIVE is 1 cycle: a `map_in` change of the selected slot appears on `map_out` on the next edge.
- `busy` is combinational from state.

## Configuration
- `MAP_HUB_SW_STAT_EN` defined:
  - `sw_cnt` increments on each QUIET→ACTIVE commit and saturates at 16'hFFFF.
  - A DEBOUNCE→ACTIVE no-blank return does not count.
- Undefined: `sw_cnt` tied to 0 and no counter logic is synthesised.

## Test plan
- Reset with `map_idx`=56, slot 0 ID=56:
  - `map_out`=0 through edge 12.
  - `map_out`=`map_in[0]` from edge 13.
  - `hit`=1, `cur_idx`=56, `sw_cnt`=1.
- Switch from 56 to 103 (slot 1) at E0 → `map_out`=0 at E4..E12, `map_in[1]` at E13, `busy` low from E12.
- Glitch 56→172→56, holding 172 for 2 cycles → no blank occurs, `map_out` stays `map_in[0]`, `sw_cnt` unchanged.
- Bouncing `map_idx` (changes every 3 cycles for 20 cycles, then holds 134) → the commit lands STABLE+QUIET+1 edges after the final change.
- Index 254 with no matching slot → `map_out`=`map_nom`, `hit`=0. Duplicate IDs in slots 2 and 5 → slot 2 is selected.
- With `MAP_HUB_SW_STAT_EN` defined, force `sw_cnt` near its limit via 65536 switches (or hierarchical preload) → the counter holds at 16'hFFFF.

Source files
------------

// File: rtl/map_hub_sw.sv
// -----------------------------------------------------------------------------
// map_hub_sw
//
// Mapper hub with glitch-free switching. Selects one of CH mapper output buses
// (or the nominal fallback bus) by matching the committed mapper index against
// a per-slot ID table, and registers the result onto map_out. A change of
// map_idx is committed only after it has held one value for STABLE cycles and
// the output has then been blanked for a QUIET window.
//
// Optional feature macro: MAP_HUB_SW_STAT_EN
//   defined   -> sw_cnt counts QUIET->ACTIVE commits, saturating at 16'hFFFF
//   undefined -> sw_cnt tied to 0, no counter logic
//
// Ports:
//   clk      in   1          system clock
//   rst      in   1          synchronous, active-high reset
//   map_idx  in   IDX_W      requested mapper number
//   slot_id  in   CH*IDX_W   slot k ID at [k*IDX_W +: IDX_W]
//   map_in   in   CH*DW      slot k output bus at [k*DW +: DW]
//   map_nom  in   DW         nominal (fallback) mapper output
//   map_out  out  DW         registered selected output
//   cur_idx  out  IDX_W      committed mapper index
//   hit      out  1          committed index matched a slot
//   busy     out  1          high while debouncing or blanking
//   sw_cnt   out  16         committed-switch counter
//
// State table:
//   state    | meaning
//   ACTIVE   | committed mapping driven onto map_out
//   DEBOUNCE | waiting for map_idx to hold one value for STABLE cycles
//   QUIET    | output forced to zero before the new index is committed
// -----------------------------------------------------------------------------
module map_hub_sw #(
    parameter int CH     = 16,
    parameter int IDX_W  = 8,
    parameter int DW     = 64,
    parameter int STABLE = 4,
    parameter int QUIET  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    map_idx,
    input  logic [CH*IDX_W-1:0] slot_id,
    input  logic [CH*DW-1:0]    map_in,
    input  logic [DW-1:0]       map_nom,
    output logic [DW-1:0]       map_out,
    output logic [IDX_W-1:0]    cur_idx,
    output logic                hit,
    output logic                busy,
    output logic [15:0]         sw_cnt
);

    localparam int CNT_MAX = (STABLE > QUIET) ? STABLE : QUIET;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE - 1);
    localparam logic [CNT_W-1:0] QT_LAST  = CNT_W'(QUIET - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE   = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_QUIET    = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_pend_idx;
    logic [IDX_W-1:0]   r_cur_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_cur_valid;
    logic [DW-1:0]      r_map_out;

    logic [DW-1:0]      w_sel;
    logic               w_hit;

    // Walk slots from the top down so the lowest matching slot overrides.
    always_comb begin
        w_sel = map_nom;
        w_hit = 1'b0;
        for (int k = CH - 1; k >= 0; k--) begin
            if (slot_id[k*IDX_W +: IDX_W] == r_cur_idx) begin
                w_sel = map_in[k*DW +: DW];
                w_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_DEBOUNCE;
            r_pend_idx  <= map_idx;
            r_cnt       <= '0;
            r_cur_valid <= 1'b0;
            r_cur_idx   <= '0;
            r_map_out   <= '0;
        end else begin
            case (r_state)
                ST_ACTIVE: begin
                    r_map_out <= w_sel;
                    if (map_idx != r_cur_idx) begin
                        r_state    <= ST_DEBOUNCE;
                        r_pend_idx <= map_idx;
                        r_cnt      <= '0;
                    end
                end
                ST_DEBOUNCE: begin
                    // Keep driving the old mapping while undecided; nothing is
                    // committed yet after reset, so drive zero then.
                    r_map_out <= r_cur_valid ? w_sel : '0;
                    if (map_idx != r_pend_idx) begin
                        r_pend_idx <= map_idx;
                        r_cnt      <= '0;
                    end else if (r_cnt == STB_LAST) begin
                        if (r_cur_valid && (r_pend_idx == r_cur_idx)) begin
                            // Glitch settled back on the committed index.
                            r_state <= ST_ACTIVE;
                        end else begin
                            r_state   <= ST_QUIET;
                            r_cnt     <= '0;
                            r_map_out <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_QUIET: begin
                    r_map_out <= '0;
                    if (r_cnt == QT_LAST) begin
                        r_cur_idx   <= r_pend_idx;
                        r_cur_valid <= 1'b1;
                        r_state     <= ST_ACTIVE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_DEBOUNCE;
                end
            endcase
        end
    end

`ifdef MAP_HUB_SW_STAT_EN
    logic [15:0] r_sw_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_cnt <= '0;
        end else if ((r_state == ST_QUIET) && (r_cnt == QT_LAST) &&
                     (r_sw_cnt != 16'hFFFF)) begin
            r_sw_cnt <= r_sw_cnt + 16'd1;
        end
    end

    assign sw_cnt = r_sw_cnt;
`else
    assign sw_cnt = 16'd0;
`endif

    assign map_out = r_map_out;
    assign cur_idx = r_cur_idx;
    assign hit     = w_hit;
    assign busy    = (r_state != ST_ACTIVE);

endmodule

// File: tb/tb_map_hub_sw.sv
module tb_map_hub_sw;

    localparam int CH     = 16;
    localparam int IDX_W  = 8;
    localparam int DW     = 64;

`ifdef MAP_HUB_SW_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [IDX_W-1:0]    map_idx;
    logic [CH*IDX_W-1:0] slot_id;
    logic [CH*DW-1:0]    map_in;
    logic [DW-1:0]       map_nom;
    logic [DW-1:0]       map_out;
    logic [IDX_W-1:0]    cur_idx;
    logic                hit;
    logic                busy;
    logic [15:0]         sw_cnt;

    int n_chk = 0;
    int n_err = 0;

    map_hub_sw #(.CH(CH), .IDX_W(IDX_W), .DW(DW), .STABLE(4), .QUIET(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .map_idx (map_idx),
        .slot_id (slot_id),
        .map_in  (map_in),
        .map_nom (map_nom),
        .map_out (map_out),
        .cur_idx (cur_idx),
        .hit     (hit),
        .busy    (busy),
        .sw_cnt  (sw_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] dat(input int k, input int salt);
        return {32'hC0DE_0000 + 32'(salt), 32'h0000_1000 + 32'(k)};
    endfunction

    function automatic logic [15:0] exp_sw(input int n);
        return STAT ? 16'(n) : 16'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [DW-1:0] d0, d1, e;

    initial begin
        for (int k = 0; k < CH; k++) begin
            slot_id[k*IDX_W +: IDX_W] = 8'(k + 1);
            map_in[k*DW +: DW]        = dat(k, 0);
        end
        slot_id[0*IDX_W +: IDX_W] = 8'd56;
        slot_id[1*IDX_W +: IDX_W] = 8'd103;
        slot_id[2*IDX_W +: IDX_W] = 8'd200;
        slot_id[5*IDX_W +: IDX_W] = 8'd200;
        map_nom = 64'hBEEF_0000_0000_F00D;
        map_idx = 8'd56;
        d0 = dat(0, 0);
        d1 = dat(1, 0);

        // Reset; the last reset edge is E0.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_map_out", map_out, 0);
        chk("rst_cur_idx", cur_idx, 0);
        chk("rst_hit", hit, 0);
        chk("rst_busy", busy, 1);
        chk("rst_sw_cnt", sw_cnt, 0);
        for (int ed = 1; ed <= 12; ed++) begin
            tick();
            chk($sformatf("boot_blank_e%0d", ed), map_out, 0);
        end
        tick();
        chk("boot_map_out_e13", map_out, d0);
        chk("boot_hit", hit, 1);
        chk("boot_cur_idx", cur_idx, 56);
        chk("boot_busy", busy, 0);
        chk("boot_sw_cnt", sw_cnt, exp_sw(1));

        // One-cycle selection latency in ACTIVE.
        d0 = dat(0, 7);
        map_in[0 +: DW] = d0;
        tick();
        chk("sel_latency", map_out, d0);

        // Switch 56 -> 103: old bus E0..E3, zero E4..E12, new bus E13.
        map_idx = 8'd103;
        for (int ed = 0; ed <= 13; ed++) begin
            tick();
            e = (ed < 4) ? d0 : ((ed <= 12) ? 64'd0 : d1);
            chk($sformatf("sw103_map_out_e%0d", ed), map_out, e);
            chk($sformatf("sw103_busy_e%0d", ed), busy, (ed < 12) ? 1 : 0);
        end
        chk("sw103_cur_idx", cur_idx, 103);
        chk("sw103_hit", hit, 1);
        chk("sw103_sw_cnt", sw_cnt, exp_sw(2));

        // Back to 56 for the glitch test.
        map_idx = 8'd56;
        repeat (14) tick();
        chk("back56_map_out", map_out, d0);
        chk("back56_sw_cnt", sw_cnt, exp_sw(3));

        // Glitch 56 -> 172 for 2 cycles -> 56: no blanking, no count.
        map_idx = 8'd172;
        tick();
        chk("glitch_map_out_e0", map_out, d0);
        tick();
        chk("glitch_map_out_e1", map_out, d0);
        map_idx = 8'd56;
        for (int ed = 2; ed <= 10; ed++) begin
            tick();
            chk($sformatf("glitch_map_out_e%0d", ed), map_out, d0);
        end
        chk("glitch_busy", busy, 0);
        chk("glitch_cur_idx", cur_idx, 56);
        chk("glitch_sw_cnt", sw_cnt, exp_sw(3));

        // Bouncing index, then hold 134 (no slot -> nominal).
        for (int v = 0; v < 7; v++) begin
            map_idx = 8'(30 + v);
            repeat (3) tick();
        end
        chk("bounce_hold_map_out", map_out, d0);
        chk("bounce_busy", busy, 1);
        map_idx = 8'd134;
        for (int ed = 0; ed <= 13; ed++) begin
            tick();
            e = (ed < 4) ? d0 : ((ed <= 12) ? 64'd0 : map_nom);
            chk($sformatf("bounce_map_out_e%0d", ed), map_out, e);
        end
        chk("bounce_cur_idx", cur_idx, 134);
        chk("bounce_hit", hit, 0);
        chk("bounce_sw_cnt", sw_cnt, exp_sw(4));

        // Unmatched 254 -> nominal bus, and it tracks map_nom.
        map_idx = 8'd254;
        repeat (14) tick();
        chk("nom254_map_out", map_out, map_nom);
        chk("nom254_hit", hit, 0);
        chk("nom254_cur_idx", cur_idx, 254);
        map_nom = 64'h1234_5678_9ABC_DEF0;
        tick();
        chk("nom254_track", map_out, 64'h1234_5678_9ABC_DEF0);

        // Duplicate ID 200 in slots 2 and 5 -> slot 2 wins.
        map_idx = 8'd200;
        repeat (14) tick();
        chk("dup_map_out", map_out, dat(2, 0));
        chk("dup_hit", hit, 1);
        chk("dup_sw_cnt", sw_cnt, exp_sw(6));

        // Reset during a switch aborts it; first commit blanks again.
        map_idx = 8'd103;
        repeat (6) tick();
        chk("abort_blanking", map_out, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_cur_idx", cur_idx, 0);
        chk("abort_busy", busy, 1);
        chk("abort_sw_cnt", sw_cnt, 0);
        repeat (12) tick();
        chk("abort_blank_e12", map_out, 0);
        tick();
        chk("abort_map_out_e13", map_out, d1);
        chk("abort_cur_idx2", cur_idx, 103);
        chk("abort_sw_cnt2", sw_cnt, exp_sw(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
